// File: rtl/bht_update_ctrl.sv
// Branch history table port arbiter: shares one single-port table between fetch lookups and buffered 2-bit counter updates.
// Optional macro BHT_INIT_SWEEP_EN adds a post-reset sweep that clears every counter.
module bht_update_ctrl #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_grant,
    input  logic             flush,
    output logic             predict_valid,
    output logic             predict_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

`ifdef BHT_INIT_SWEEP_EN
    typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;
    localparam state_t RESET_STATE = INIT;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t           state, next_state;
    logic [1:0]       starve_cnt;
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [IDX_W-1:0] fifo_idx   [FIFO_DEPTH];
    logic             fifo_taken [FIFO_DEPTH];
    logic             empty, full, push, pop;
    logic             starve_inc, starve_clr;
    logic             grant_int, en_int, we_int;
    logic [IDX_W-1:0] addr_int;
    logic [1:0]       wdata_int, sat_inc, sat_dec;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
`ifdef BHT_INIT_SWEEP_EN
    logic [IDX_W-1:0] sweep_addr;
`endif

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign upd_ready  = !full;
    assign push       = upd_valid && !full;
    assign head_idx   = fifo_idx[rd_ptr[PTR_W-1:0]];
    assign head_taken = fifo_taken[rd_ptr[PTR_W-1:0]];
    assign sat_inc    = (tbl_rdata == 2'b11) ? 2'b11 : tbl_rdata + 2'd1;
    assign sat_dec    = (tbl_rdata == 2'b00) ? 2'b00 : tbl_rdata - 2'd1;

    always_comb begin
        next_state = state;
        grant_int  = 1'b0;
        en_int     = 1'b0;
        we_int     = 1'b0;
        addr_int   = '0;
        wdata_int  = '0;
        pop        = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state)
`ifdef BHT_INIT_SWEEP_EN
            INIT: begin
                en_int   = 1'b1;
                we_int   = 1'b1;
                addr_int = sweep_addr;
                if (sweep_addr == '1)
                    next_state = IDLE;
            end
`endif
            IDLE: begin
                // fetch wins unless a pending update has already waited three grants
                if (lookup_valid && !(starve_cnt == 2'd3 && !empty)) begin
                    grant_int  = 1'b1;
                    en_int     = 1'b1;
                    addr_int   = lookup_idx;
                    starve_inc = !empty;
                end else if (!empty) begin
                    en_int     = 1'b1;
                    addr_int   = head_idx;
                    starve_clr = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                en_int     = 1'b1;
                we_int     = 1'b1;
                addr_int   = head_idx;
                wdata_int  = head_taken ? sat_inc : sat_dec;
                pop        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = RESET_STATE;
        endcase
    end

    // table strobes are forced quiet while reset is held, independent of state
    assign lookup_grant  = rst_n && grant_int;
    assign tbl_en        = rst_n && en_int;
    assign tbl_we        = rst_n && we_int;
    assign tbl_addr      = rst_n ? addr_int : '0;
    assign tbl_wdata     = rst_n ? wdata_int : '0;
    assign predict_taken = predict_valid && tbl_rdata[1];

`ifdef BHT_INIT_SWEEP_EN
    assign init_busy = (state == INIT);
`else
    assign init_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_STATE;
            starve_cnt    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            predict_valid <= 1'b0;
        end else begin
            state         <= next_state;
            wr_ptr        <= wr_ptr + (PTR_W+1)'(push);
            rd_ptr        <= rd_ptr + (PTR_W+1)'(pop);
            predict_valid <= grant_int && !flush;
            if (starve_clr)
                starve_cnt <= '0;
            else if (starve_inc && starve_cnt != 2'd3)
                starve_cnt <= starve_cnt + 2'd1;
        end
    end

`ifdef BHT_INIT_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sweep_addr <= '0;
        else if (state == INIT)
            sweep_addr <= sweep_addr + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr[PTR_W-1:0]]   <= upd_idx;
            fifo_taken[wr_ptr[PTR_W-1:0]] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed self-checking bench for bht_update_ctrl; follows BHT_INIT_SWEEP_EN to pick the reset-release path.
module tb_bht_update_ctrl;

    localparam int unsigned IDX_W = 6;

`ifdef BHT_INIT_SWEEP_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_grant;
    logic             flush;
    logic             predict_valid;
    logic             predict_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;
    logic             init_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [IDX_W-1:0] q_idx [5] = '{6'd9, 6'd10, 6'd11, 6'd12, 6'd13};
    logic             q_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    bht_update_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_idx   (lookup_idx),
        .lookup_grant (lookup_grant),
        .flush        (flush),
        .predict_valid(predict_valid),
        .predict_taken(predict_taken),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .tbl_en       (tbl_en),
        .tbl_we       (tbl_we),
        .tbl_addr     (tbl_addr),
        .tbl_wdata    (tbl_wdata),
        .tbl_rdata    (tbl_rdata),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Releases reset on the first iteration, then checks every sweep write; optionally pushes the 5-entry list.
    task automatic sweep(input bit push5);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rst_n        = 1'b1;
            lookup_valid = 1'b1;
            lookup_idx   = 6'd5;
            if (push5 && i < 5) begin
                upd_valid = 1'b1;
                upd_idx   = q_idx[i];
                upd_taken = q_tk[i];
            end else begin
                upd_valid = 1'b0;
            end
            #1;
            chk("sweep_en",    tbl_en,    1);
            chk("sweep_we",    tbl_we,    1);
            chk("sweep_addr",  tbl_addr,  i);
            chk("sweep_wdata", tbl_wdata, 0);
            chk("sweep_busy",  init_busy, 1);
            chk("sweep_grant", lookup_grant, 0);
            if (push5 && i < 5)
                chk("init_upd_ready", upd_ready, (i < 4) ? 1 : 0);
        end
    endtask

    // Each queued update: read of its index, then a write of sat(01 +/- 1).
    task automatic drain(input int unsigned first);
        for (int unsigned k = first; k < 4; k++) begin
            @(negedge clk);
            lookup_valid = 1'b0;
            upd_valid    = 1'b0;
            #1;
            chk("drain_rd_en",   tbl_en,    1);
            chk("drain_rd_we",   tbl_we,    0);
            chk("drain_rd_addr", tbl_addr,  q_idx[k]);
            chk("drain_busy",    init_busy, 0);
            @(negedge clk);
            tbl_rdata = 2'b01;
            #1;
            chk("drain_wr_we",    tbl_we,    1);
            chk("drain_wr_addr",  tbl_addr,  q_idx[k]);
            chk("drain_wr_wdata", tbl_wdata, q_tk[k] ? 2'b10 : 2'b00);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        lookup_valid = 1'b1;
        lookup_idx   = 6'd5;
        flush        = 1'b0;
        upd_valid    = 1'b0;
        upd_idx      = '0;
        upd_taken    = 1'b0;
        tbl_rdata    = 2'b00;

        // held in reset with a lookup pending
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_tbl_en",    tbl_en,        0);
        chk("rst_tbl_we",    tbl_we,        0);
        chk("rst_grant",     lookup_grant,  0);
        chk("rst_pvalid",    predict_valid, 0);
        chk("rst_ptaken",    predict_taken, 0);
        chk("rst_upd_ready", upd_ready,     1);
        chk("rst_init_busy", init_busy,     EXP_BUSY);

`ifdef BHT_INIT_SWEEP_EN
        // 5 pushes during the sweep: 4 accepted, then applied in order
        sweep(1'b1);
        drain(0);
`else
        @(negedge clk);
        rst_n        = 1'b1;
        lookup_valid = 1'b0;
        #1;
        chk("rel_busy",   init_busy,    0);
        chk("rel_tbl_en", tbl_en,       0);
        chk("rel_grant",  lookup_grant, 0);
        // 5 pushes while fetch holds the port: 4 accepted, starvation forces the first update out
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            lookup_valid = 1'b1;
            lookup_idx   = 6'd5;
            upd_valid    = 1'b1;
            upd_idx      = q_idx[c];
            upd_taken    = q_tk[c];
            #1;
            chk("fill_grant", lookup_grant, 1);
            chk("fill_ready", upd_ready,    1);
        end
        @(negedge clk);
        upd_idx   = q_idx[4];
        upd_taken = q_tk[4];
        #1;
        chk("full_ready",   upd_ready,    0);
        chk("full_grant",   lookup_grant, 0);
        chk("full_rd_en",   tbl_en,       1);
        chk("full_rd_we",   tbl_we,       0);
        chk("full_rd_addr", tbl_addr,     9);
        @(negedge clk);
        upd_valid    = 1'b0;
        lookup_valid = 1'b0;
        tbl_rdata    = 2'b01;
        #1;
        chk("full_wr_we",    tbl_we,    1);
        chk("full_wr_addr",  tbl_addr,  9);
        chk("full_wr_wdata", tbl_wdata, 2'b10);
        drain(1);
`endif

        // lookup idx 5, counter 10 -> taken
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_idx   = 6'd5;
        #1;
        chk("lk_grant", lookup_grant, 1);
        chk("lk_en",    tbl_en,       1);
        chk("lk_we",    tbl_we,       0);
        chk("lk_addr",  tbl_addr,     5);
        @(negedge clk);
        lookup_valid = 1'b0;
        tbl_rdata    = 2'b10;
        #1;
        chk("lk_pvalid", predict_valid, 1);
        chk("lk_ptaken", predict_taken, 1);

        // counter 01 -> not taken
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_idx   = 6'd6;
        #1;
        chk("lk2_addr", tbl_addr, 6);
        @(negedge clk);
        lookup_valid = 1'b0;
        tbl_rdata    = 2'b01;
        #1;
        chk("lk2_pvalid", predict_valid, 1);
        chk("lk2_ptaken", predict_taken, 0);

        // flush in the grant cycle drops the prediction
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_idx   = 6'd5;
        flush        = 1'b1;
        #1;
        chk("fl_grant", lookup_grant, 1);
        @(negedge clk);
        lookup_valid = 1'b0;
        flush        = 1'b0;
        tbl_rdata    = 2'b10;
        #1;
        chk("fl_pvalid", predict_valid, 0);
        chk("fl_ptaken", predict_taken, 0);

        // update idx 9 taken on a saturated counter
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = 6'd9;
        upd_taken = 1'b1;
        #1;
        chk("u1_idle_en", tbl_en, 0);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("u1_rd_en",   tbl_en,   1);
        chk("u1_rd_we",   tbl_we,   0);
        chk("u1_rd_addr", tbl_addr, 9);
        @(negedge clk);
        tbl_rdata = 2'b11;
        #1;
        chk("u1_wr_we",    tbl_we,    1);
        chk("u1_wr_addr",  tbl_addr,  9);
        chk("u1_wr_wdata", tbl_wdata, 2'b11);

        // not taken at 00 saturates low; flush must not disturb it
        @(negedge clk);
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        flush     = 1'b1;
        #1;
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("u0_rd_addr", tbl_addr, 9);
        chk("u0_rd_we",   tbl_we,   0);
        @(negedge clk);
        tbl_rdata = 2'b00;
        #1;
        chk("u0_wr_we",    tbl_we,    1);
        chk("u0_wr_wdata", tbl_wdata, 2'b00);
        flush = 1'b0;

        // one queued update versus a continuous lookup stream
        @(negedge clk);
        upd_valid    = 1'b1;
        upd_idx      = 6'd20;
        upd_taken    = 1'b1;
        lookup_valid = 1'b1;
        lookup_idx   = 6'd3;
        #1;
        chk("st_grant0", lookup_grant, 1);
        chk("st_addr0",  tbl_addr,     3);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            upd_valid = 1'b0;
            #1;
            chk("st_grant", lookup_grant, 1);
        end
        @(negedge clk); #1;
        chk("st_rd_grant", lookup_grant, 0);
        chk("st_rd_en",    tbl_en,       1);
        chk("st_rd_we",    tbl_we,       0);
        chk("st_rd_addr",  tbl_addr,     20);
        @(negedge clk);
        tbl_rdata = 2'b10;
        #1;
        chk("st_wr_grant",  lookup_grant,  0);
        chk("st_wr_we",     tbl_we,        1);
        chk("st_wr_addr",   tbl_addr,      20);
        chk("st_wr_wdata",  tbl_wdata,     2'b11);
        chk("st_wr_pvalid", predict_valid, 0);
        @(negedge clk); #1;
        chk("st_regrant", lookup_grant, 1);

        // reset asserted while in WRITE
        @(negedge clk);
        lookup_valid = 1'b0;
        upd_valid    = 1'b1;
        upd_idx      = 6'd7;
        upd_taken    = 1'b1;
        #1;
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("rw_rd_addr", tbl_addr, 7);
        @(negedge clk);
        tbl_rdata = 2'b01;
        rst_n     = 1'b0;
        #1;
        chk("rw_tbl_en", tbl_en,    0);
        chk("rw_tbl_we", tbl_we,    0);
        chk("rw_ready",  upd_ready, 1);
        chk("rw_busy",   init_busy, EXP_BUSY);
        @(negedge clk);
`ifdef BHT_INIT_SWEEP_EN
        sweep(1'b0);
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
`else
        rst_n        = 1'b1;
        lookup_valid = 1'b0;
        #1;
        chk("rw_rel_busy", init_busy, 0);
        @(negedge clk); #1;
`endif
        chk("rw_fifo_empty", tbl_en, 0);
        @(negedge clk); #1;
        chk("rw_fifo_empty2", tbl_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
